// File: rtl/riscv_pkg.sv
// Shared RV32I constants: opcodes, ALU operation codes, next-PC select codes.
// No logic of its own; arith_op maps funct3/funct7[5] to an ALU code.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_OR    = 4'h3;
   localparam logic [3:0] ALU_XOR   = 4'h4;
   localparam logic [3:0] ALU_SLL   = 4'h5;
   localparam logic [3:0] ALU_SRL   = 4'h6;
   localparam logic [3:0] ALU_SRA   = 4'h7;
   localparam logic [3:0] ALU_SLT   = 4'h8;
   localparam logic [3:0] ALU_SLTU  = 4'h9;
   localparam logic [3:0] ALU_PASSB = 4'hA;

   localparam logic [1:0] PCS_PLUS4  = 2'b00;
   localparam logic [1:0] PCS_BRANCH = 2'b01;
   localparam logic [1:0] PCS_JALR   = 2'b10;

   // funct7[5] means SUB only for register ops; for shifts it picks SRA in both forms.
   function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt,
                                           input logic is_reg);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I ALU: result and zero flag from a, b and alu_op.
// Latency: zero cycles; no flow control.
module exec_alu
   import riscv_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_op,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   logic [4:0]              shamt;
   logic signed [WIDTH-1:0] a_s;

   assign shamt = b[4:0];
   assign a_s   = a;

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_SLL:   result = a << shamt;
         ALU_SRL:   result = a >> shamt;
         ALU_SRA:   result = a_s >>> shamt;
         ALU_SLT:   result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, a < b};
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/riscv_exec_mem_unit.sv
// Decode, ALU, branch compare and word data memory of the single-cycle RV32I core.
// Latency: combinational except the store port (posedge clk); no flow control.
module riscv_exec_mem_unit #(
   parameter int XLEN       = 32,
   parameter int DMEM_WORDS = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] inst,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [XLEN-1:0] imm,
   output logic            reg_write,
   output logic            mem_to_reg,
   output logic            jump,
   output logic            alu_src,
   output logic [3:0]      alu_op,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic [1:0]      pc_src,
   output logic [XLEN-1:0] alu_result,
   output logic            zero,
   output logic [XLEN-1:0] mem_read_data
);
   import riscv_pkg::*;

   localparam int AW = $clog2(DMEM_WORDS);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            alt;
   logic            use_pc;
   logic            br_taken;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [AW-1:0]   word_idx;
   logic [XLEN-1:0] mem [DMEM_WORDS];
   logic            unused_bits;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign alt    = inst[30];

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  br_taken = (rs1_val <  rs2_val);
         3'b111:  br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      jump       = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      pc_src     = PCS_PLUS4;
      use_pc     = 1'b0;
      case (opcode)
         OP_R: begin
            reg_write = 1'b1;
            alu_op    = arith_op(funct3, alt, 1'b1);
         end
         OP_I: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_op    = arith_op(funct3, alt, 1'b0);
         end
         OP_LOAD: begin
            reg_write  = 1'b1;
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            alu_src    = 1'b1;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
         end
         OP_BRANCH: begin
            branch = 1'b1;
            alu_op = ALU_SUB;
            if (br_taken) pc_src = PCS_BRANCH;
         end
         OP_JAL: begin
            reg_write = 1'b1;
            jump      = 1'b1;
            pc_src    = PCS_BRANCH;
         end
         OP_JALR: begin
            reg_write = 1'b1;
            jump      = 1'b1;
            alu_src   = 1'b1;
            pc_src    = PCS_JALR;
         end
         OP_LUI: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_op    = ALU_PASSB;
         end
         OP_AUIPC: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            use_pc    = 1'b1;
         end
         default: ;
      endcase
   end

   assign op_a = use_pc  ? pc  : rs1_val;
   assign op_b = alu_src ? imm : rs2_val;

   exec_alu #(.WIDTH(XLEN)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .alu_op (alu_op),
      .result (alu_result),
      .zero   (zero)
   );

   // Address wraps modulo the memory size; byte offset is dropped.
   assign word_idx = alu_result[AW+1:2];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
      end else if (mem_write) begin
         mem[word_idx] <= rs2_val;
      end
   end

   assign mem_read_data = mem_read ? mem[word_idx] : '0;

   assign unused_bits = ^{inst[31], inst[29:15], inst[11:7],
                          alu_result[XLEN-1:AW+2], alu_result[1:0]};

endmodule

// File: tb/tb_riscv_exec_mem_unit.sv
// Bench for riscv_exec_mem_unit: directed cases plus randomized instructions
// checked against an instruction-level reference model with a word-array memory.
module tb_riscv_exec_mem_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst, pc, rs1_val, rs2_val, imm;
   logic        reg_write, mem_to_reg, jump, alu_src, mem_read, mem_write, branch, zero;
   logic [3:0]  alu_op;
   logic [1:0]  pc_src;
   logic [31:0] alu_result, mem_read_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ref_mem [256];

   typedef struct packed {
      logic        rw, m2r, jmp, asrc, mr, mw, br;
      logic [3:0]  op;
      logic [1:0]  pcs;
      logic [31:0] res;
   } exp_t;

   riscv_exec_mem_unit #(.XLEN(32), .DMEM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .pc(pc), .rs1_val(rs1_val),
      .rs2_val(rs2_val), .imm(imm), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .jump(jump), .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
      .mem_write(mem_write), .branch(branch), .pc_src(pc_src), .alu_result(alu_result),
      .zero(zero), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // {alu code, architectural result} for the OP / OP-IMM arithmetic family.
   function automatic logic [35:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub, input logic [31:0] a,
                                          input logic [31:0] b);
      int sh;
      logic signed [31:0] sa;
      sh = int'(b[4:0]);
      sa = a;
      case (f3)
         3'd0: if (allow_sub && alt) return {4'd1, a - b}; else return {4'd0, a + b};
         3'd1: return {4'd5, a << sh};
         3'd2: return {4'd8, 31'd0, $signed(a) < $signed(b)};
         3'd3: return {4'd9, 31'd0, a < b};
         3'd4: return {4'd4, a ^ b};
         3'd5: if (alt) return {4'd7, 32'(sa >>> sh)}; else return {4'd6, a >> sh};
         3'd6: return {4'd3, a | b};
         default: return {4'd2, a & b};
      endcase
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] im);
      exp_t e;
      logic [2:0] f3;
      logic taken;
      e  = '0;
      f3 = ins[14:12];
      case (ins[6:0])
         7'h33: begin e.rw = 1; {e.op, e.res} = arith(f3, ins[30], 1'b1, a, b); end
         7'h13: begin e.rw = 1; e.asrc = 1; {e.op, e.res} = arith(f3, ins[30], 1'b0, a, im); end
         7'h03: begin e.rw = 1; e.mr = 1; e.m2r = 1; e.asrc = 1; e.res = a + im; end
         7'h23: begin e.mw = 1; e.asrc = 1; e.res = a + im; end
         7'h63: begin
            e.br = 1; e.op = 4'd1; e.res = a - b;
            case (f3)
               3'd0: taken = (a == b);
               3'd1: taken = (a != b);
               3'd4: taken = $signed(a) <  $signed(b);
               3'd5: taken = $signed(a) >= $signed(b);
               3'd6: taken = a <  b;
               3'd7: taken = a >= b;
               default: taken = 1'b0;
            endcase
            e.pcs = taken ? 2'b01 : 2'b00;
         end
         7'h6F: begin e.rw = 1; e.jmp = 1; e.pcs = 2'b01; e.res = a + b; end
         7'h67: begin e.rw = 1; e.jmp = 1; e.asrc = 1; e.pcs = 2'b10; e.res = a + im; end
         7'h37: begin e.rw = 1; e.asrc = 1; e.op = 4'hA; e.res = im; end
         7'h17: begin e.rw = 1; e.asrc = 1; e.res = p + im; end
         default: e.res = a + b;
      endcase
      return e;
   endfunction

   // Drive one instruction, compare every output mid-cycle, then clock it.
   task automatic apply(input string name, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
      exp_t e;
      inst = ins; pc = p; rs1_val = a; rs2_val = b; imm = im;
      e = model(ins, p, a, b, im);
      @(negedge clk);
      check({name, ".reg_write"},  32'(reg_write),  32'(e.rw));
      check({name, ".mem_to_reg"}, 32'(mem_to_reg), 32'(e.m2r));
      check({name, ".jump"},       32'(jump),       32'(e.jmp));
      check({name, ".alu_src"},    32'(alu_src),    32'(e.asrc));
      check({name, ".mem_read"},   32'(mem_read),   32'(e.mr));
      check({name, ".mem_write"},  32'(mem_write),  32'(e.mw));
      check({name, ".branch"},     32'(branch),     32'(e.br));
      check({name, ".alu_op"},     32'(alu_op),     32'(e.op));
      check({name, ".pc_src"},     32'(pc_src),     32'(e.pcs));
      check({name, ".alu_result"}, alu_result,      e.res);
      check({name, ".zero"},       32'(zero),       32'(e.res == 32'd0));
      check({name, ".rdata"},      mem_read_data,   e.mr ? ref_mem[e.res[9:2]] : 32'd0);
      if (rst_n) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
      end else if (e.mw) begin
         ref_mem[e.res[9:2]] = b;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] opc);
      return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
   endfunction

   logic [6:0] opc_pool [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h7F, 7'h00};

   initial begin
      logic [31:0] ri, ra, rb, rim;
      logic [6:0]  opc;
      rst_n = 1'b1;
      inst = 32'd0; pc = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0; imm = 32'd0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.reg_write", 32'(reg_write), 32'd0);
      check("reset.pc_src",    32'(pc_src),    32'd0);
      check("reset.rdata",     mem_read_data,  32'd0);
      @(posedge clk); #1;

      // Store attempted under reset must not land.
      apply("rst_sw", enc(7'd0, 3'd2, 7'h23), 32'd0, 32'h100, 32'hDEADBEEF, 32'd0);
      rst_n = 1'b0;
      apply("rst_lw", enc(7'd0, 3'd2, 7'h03), 32'd0, 32'h100, 32'd0, 32'd0);
      check("rst_lw.const", mem_read_data, 32'd0);

      apply("add", 32'h002081B3, 32'd0, 32'd5, 32'd7, 32'd0);
      check("add.const", alu_result, 32'd12);
      apply("srai", 32'h40115193, 32'd0, 32'h80000000, 32'd0, 32'h401);
      check("srai.const", alu_result, 32'hC0000000);
      apply("sw", enc(7'd0, 3'd2, 7'h23), 32'd0, 32'h100, 32'hDEADBEEF, 32'd4);
      apply("lw", enc(7'd0, 3'd2, 7'h03), 32'd0, 32'h100, 32'd0, 32'd4);
      check("lw.const", mem_read_data, 32'hDEADBEEF);
      apply("blt",  enc(7'd0, 3'd4, 7'h63), 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
      check("blt.const", 32'(pc_src), 32'd1);
      apply("bltu", enc(7'd0, 3'd6, 7'h63), 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0);
      check("bltu.const", 32'(pc_src), 32'd0);
      apply("beq",  enc(7'd0, 3'd0, 7'h63), 32'd0, 32'd9, 32'd9, 32'd0);
      check("beq.const", 32'({pc_src, zero}), 32'b011);
      apply("b010", enc(7'd0, 3'd2, 7'h63), 32'd0, 32'd9, 32'd9, 32'd0);
      apply("jal",  enc(7'd0, 3'd0, 7'h6F), 32'h40, 32'd1, 32'd2, 32'd8);
      apply("jalr", enc(7'd0, 3'd0, 7'h67), 32'h40, 32'h200, 32'd2, 32'd8);
      check("jalr.const", 32'(pc_src), 32'd2);
      apply("lui",  enc(7'd0, 3'd0, 7'h37), 32'd0, 32'd3, 32'd4, 32'h12345000);
      check("lui.const", alu_result, 32'h12345000);
      apply("auipc", enc(7'd0, 3'd0, 7'h17), 32'h1000, 32'd3, 32'd4, 32'h20);
      apply("nop7f", enc(7'h7F, 3'd7, 7'h7F), 32'd0, 32'd3, 32'd4, 32'd5);
      check("nop7f.const", 32'({reg_write, mem_to_reg, jump, alu_src, mem_read,
                                mem_write, branch, pc_src}), 32'd0);
      apply("sw_wrap", enc(7'd0, 3'd2, 7'h23), 32'd0, 32'h400, 32'hCAFEF00D, 32'd0);
      apply("lw_wrap", enc(7'd0, 3'd2, 7'h03), 32'd0, 32'd0, 32'd0, 32'd0);
      check("lw_wrap.const", mem_read_data, 32'hCAFEF00D);

      for (int n = 0; n < 500; n++) begin
         opc = opc_pool[$urandom_range(0, 10)];
         ri  = {$urandom} & 32'hFFFF_FF80 | {25'd0, opc};
         case ($urandom_range(0, 3))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         rim = $urandom;
         if (opc == 7'h03 || opc == 7'h23) begin
            ra  = ($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 10);
            rim = $urandom_range(0, 3) << 2;
         end
         rst_n = ($urandom_range(0, 49) == 0);
         apply("rand", ri, $urandom, ra, rb, rim);
      end
      rst_n = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
